// File: rtl/iir_filter_pkg.sv
// Shared widths, fixed-point constants, default coefficients and helpers for iir_filter.
package iir_filter_pkg;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int RES_W     = 24;
  localparam int ACC_W     = 48;
  localparam int COEF_FRAC = 14;
  localparam int RES_FRAC  = 8;

  localparam logic signed [COEF_W-1:0] B0_DEF = 16'sd16384;
  localparam logic signed [COEF_W-1:0] B1_DEF = 16'sd0;
  localparam logic signed [COEF_W-1:0] B2_DEF = 16'sd0;
  localparam logic signed [COEF_W-1:0] A1_DEF = -16'sd8192;
  localparam logic signed [COEF_W-1:0] A2_DEF = 16'sd0;

  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'(2 ** (RES_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] RES_MIN = -RES_MAX - ACC_W'(1);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [RES_W-1:0]  q16_8_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef struct packed {
    sample_t x1;
    sample_t x2;
    q16_8_t  y1;
    q16_8_t  y2;
  } hist_t;

  // Integer sample times Q2.14 coefficient, aligned to the 22 fractional bits of the accumulator.
  function automatic acc_t mul_ff(input logic signed [COEF_W-1:0] c, input sample_t x);
    acc_t cw, xw;
    cw = ACC_W'(c);
    xw = ACC_W'(x);
    return (cw * xw) <<< RES_FRAC;
  endfunction

  function automatic acc_t mul_fb(input logic signed [COEF_W-1:0] c, input q16_8_t y);
    acc_t cw, yw;
    cw = ACC_W'(c);
    yw = ACC_W'(y);
    return cw * yw;
  endfunction

endpackage

// File: rtl/iir_filter_mac.sv
// Combinational five-tap biquad multiply-accumulate, requantise to Q16.8.
// Saturates when IIR_FILTER_SAT_EN is defined, otherwise wraps to 24 bits.
module iir_filter_mac
  import iir_filter_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] B0 = B0_DEF,
  parameter logic signed [COEF_W-1:0] B1 = B1_DEF,
  parameter logic signed [COEF_W-1:0] B2 = B2_DEF,
  parameter logic signed [COEF_W-1:0] A1 = A1_DEF,
  parameter logic signed [COEF_W-1:0] A2 = A2_DEF
) (
  input  sample_t x0_i,
  input  sample_t x1_i,
  input  sample_t x2_i,
  input  q16_8_t  y1_i,
  input  q16_8_t  y2_i,
  output q16_8_t  y_o
);

  acc_t acc;
  acc_t acc_shr;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    acc = mul_ff(B0, x0_i) + mul_ff(B1, x1_i) + mul_ff(B2, x2_i)
        - mul_fb(A1, y1_i) - mul_fb(A2, y2_i);
    acc_shr = acc >>> COEF_FRAC;
`ifdef IIR_FILTER_SAT_EN
    if (acc_shr > RES_MAX)      y_o = RES_W'(RES_MAX);
    else if (acc_shr < RES_MIN) y_o = RES_W'(RES_MIN);
    else                        y_o = RES_W'(acc_shr);
`else
    y_o = RES_W'(acc_shr);
`endif
  end

endmodule

// File: rtl/iir_filter.sv
// Direct-form-I biquad IIR filter with strobe-qualified history and registered Q16.8 output.
// Optional build macro IIR_FILTER_SAT_EN selects saturation instead of wrap on the output.
module iir_filter
  import iir_filter_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] B0 = B0_DEF,
  parameter logic signed [COEF_W-1:0] B1 = B1_DEF,
  parameter logic signed [COEF_W-1:0] B2 = B2_DEF,
  parameter logic signed [COEF_W-1:0] A1 = A1_DEF,
  parameter logic signed [COEF_W-1:0] A2 = A2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_en,
  input  logic [DATA_W-1:0] data,
  output logic [RES_W-1:0]  result
);

  hist_t  hist_q, hist_d;
  q16_8_t result_q, result_d;
  q16_8_t y;

  iir_filter_mac #(
    .B0(B0), .B1(B1), .B2(B2), .A1(A1), .A2(A2)
  ) u_mac (
    .x0_i (sample_t'(data)),
    .x1_i (hist_q.x1),
    .x2_i (hist_q.x2),
    .y1_i (hist_q.y1),
    .y2_i (hist_q.y2),
    .y_o  (y)
  );

  always_comb begin
    hist_d   = hist_q;
    result_d = result_q;
    if (data_en) begin
      result_d  = y;
      hist_d.x1 = sample_t'(data);
      hist_d.x2 = hist_q.x1;
      hist_d.y1 = y;
      hist_d.y2 = hist_q.y1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all history taps shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      result_q <= '0;
    end else begin
      hist_q   <= hist_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_iir_filter.sv
// Directed self-checking bench for iir_filter: default biquad, reset, overflow and FIR impulse.
module tb_iir_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_en = 1'b0;
  logic [15:0] data = '0;
  logic [23:0] result;
  logic [23:0] fir_result;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        en;
    logic [15:0] d;
    int          exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  iir_filter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_en (data_en),
    .data    (data),
    .result  (result)
  );

  iir_filter #(
    .B0(16'sd16384), .B1(16'sd16384), .B2(16'sd16384), .A1(16'sd0), .A2(16'sd0)
  ) dut_fir (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_en (data_en),
    .data    (data),
    .result  (fir_result)
  );

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic en, input logic [15:0] d);
    @(negedge clk);
    data_en = en;
    data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("reset_async_clear", $signed(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic en, input logic [15:0] d, input int exp);
    vec_t v;
    v.en  = en;
    v.d   = d;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    int exp_sat2;

    vecs.push_back(mk(1'b1, 16'd1, 256));
    vecs.push_back(mk(1'b1, 16'd2, 640));
    vecs.push_back(mk(1'b1, 16'd3, 1088));
    vecs.push_back(mk(1'b1, 16'd4, 1568));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, 16'hA5A5 ^ 16'(i * 16'h1357), 1568));
    vecs.push_back(mk(1'b1, 16'd1, 1040));
    vecs.push_back(mk(1'b1, 16'd2, 1032));
    vecs.push_back(mk(1'b1, 16'd3, 1284));
    vecs.push_back(mk(1'b1, 16'd4, 1666));
    vecs.push_back(mk(1'b1, 16'd5, 2113));
    vecs.push_back(mk(1'b1, 16'd6, 2592));
    vecs.push_back(mk(1'b1, 16'd7, 3088));

    #2;
    check("reset_result", $signed(result), 0);
    check("reset_fir_result", $signed(fir_result), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].d);
      check($sformatf("vec%0d", i), $signed(result), vecs[i].exp);
    end

    // Reset mid-burst: result must clear without a clock edge, history must restart.
    step(1'b1, 16'd9);
    @(negedge clk);
    data_en = 1'b1;
    data    = 16'd11;
    #2;
    rst_n = 1'b0;
    #1;
    check("midburst_reset_async", $signed(result), 0);
    @(posedge clk);
    #1;
    check("midburst_reset_held", $signed(result), 0);
    @(negedge clk);
    data_en = 1'b0;
    rst_n   = 1'b1;
    step(1'b1, 16'd1);
    check("post_reset_first", $signed(result), 256);
    step(1'b1, 16'd2);
    check("post_reset_second", $signed(result), 640);

    // Full-scale input twice: second output exceeds the 24-bit range.
    do_reset();
`ifdef IIR_FILTER_SAT_EN
    exp_sat2 = 8388607;
`else
    exp_sat2 = -4194688;
`endif
    step(1'b1, 16'd32767);
    check("overflow_first", $signed(result), 8388352);
    step(1'b1, 16'd32767);
    check("overflow_second", $signed(result), exp_sat2);

    // FIR coefficients: impulse of 100 rings for three taps then dies.
    do_reset();
    step(1'b1, 16'd100);
    check("fir_tap0", $signed(fir_result), 25600);
    step(1'b1, 16'd0);
    check("fir_tap1", $signed(fir_result), 25600);
    step(1'b1, 16'd0);
    check("fir_tap2", $signed(fir_result), 25600);
    step(1'b1, 16'd0);
    check("fir_tap3", $signed(fir_result), 0);

    // Negative input exercises floor rounding: -1 -> -256, then -2 -> -512 + floor(-128) = -640.
    do_reset();
    step(1'b1, 16'hFFFF);
    check("neg_first", $signed(result), -256);
    step(1'b1, 16'hFFFE);
    check("neg_second", $signed(result), -640);
    step(1'b1, 16'd1);
    check("neg_third", $signed(result), -64);
    step(1'b1, 16'd0);
    check("neg_floor", $signed(result), -32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
